// File: rtl/mem_port_arb.sv
// mem_port_arb: round-robin arbiter sharing one memory port
// between instruction fetch and data access, with wait timeout.
module mem_port_arb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE,
    I_ACC,
    D_ACC,
    RESP
  } state_e;

  // Abort fires on the TIMEOUT-th unanswered access cycle.
  localparam logic [7:0] ToLast = 8'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic          last_d_q, last_d_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          m_req_q, m_req_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          i_done_q, i_done_d;
  logic          d_done_q, d_done_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  // State and registered-output flops; last grant resets to data.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b1;
      cnt_q     <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      cnt_q     <= cnt_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state: grant, wait/timeout, one-cycle response.
  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    cnt_d     = cnt_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req && (!d_req || last_d_q)) begin
          state_d  = I_ACC;
          last_d_d = 1'b0;
          cnt_d    = '0;
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = i_addr;
        end else if (d_req) begin
          state_d   = D_ACC;
          last_d_d  = 1'b1;
          cnt_d     = '0;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
        end
      end
      I_ACC, D_ACC: begin
        if (m_ready || cnt_q == ToLast) begin
          state_d = RESP;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          err_d   = !m_ready;
          if (state_q == I_ACC) begin
            i_done_d  = 1'b1;
            i_rdata_d = m_ready ? m_rdata : '0;
          end else begin
            d_done_d = 1'b1;
            if (!m_we_q) begin
              d_rdata_d = m_ready ? m_rdata : '0;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign i_rdata = i_rdata_q;
  assign i_done  = i_done_q;
  assign d_rdata = d_rdata_q;
  assign d_done  = d_done_q;
  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: scoreboard bench for mem_port_arb
// with TIMEOUT=4 and a latency-programmable memory responder.
module tb_mem_port_arb;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        busy;
  logic        err;

  typedef struct {
    bit          is_i;
    logic [31:0] rdata;
    logic [31:0] other;
    bit          err;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    int          len;
  } acc_t;

  resp_t rq[$];
  acc_t  aq[$];
  int    checks = 0;
  int    failures = 0;
  int    lat = 0;

  mem_port_arb #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_done  (i_done),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_done  (d_done),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  task automatic push_r(input bit is_i, input logic [31:0] rd,
                        input logic [31:0] oth, input bit e);
    resp_t r;
    r.is_i = is_i; r.rdata = rd; r.other = oth; r.err = e;
    rq.push_back(r);
  endtask

  task automatic push_a(input logic [31:0] a, input bit we,
                        input logic [31:0] wd, input int len);
    acc_t x;
    x.addr = a; x.we = we; x.wdata = wd; x.len = len;
    aq.push_back(x);
  endtask

  task automatic wait_done(input bit is_i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_i ? i_done : d_done) && n < 40);
    check(is_i ? "i_done_wait" : "d_done_wait",
          32'(is_i ? i_done : d_done), 32'd1);
  endtask

  task automatic hold_i(input int cnt);
    for (int k = 0; k < cnt; k++) wait_done(1'b1);
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic hold_d(input int cnt);
    for (int k = 0; k < cnt; k++) wait_done(1'b0);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  // Memory model: answers after `lat` wait cycles, checks each access.
  initial begin
    bit   act = 0;
    int   len = 0;
    acc_t cur;
    acc_t ex;
    m_ready = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (m_req) begin
        if (!act) begin
          act = 1; len = 0;
          cur.addr = m_addr; cur.we = m_we; cur.wdata = m_wdata;
        end
        len++;
        if (len - 1 == lat) begin
          m_ready = 1'b1;
          m_rdata = m_addr + 32'h1000_0000;
        end else begin
          m_ready = 1'b0;
          m_rdata = 32'hBAD0_BAD0;
        end
      end else begin
        if (act) begin
          act = 0;
          if (aq.size() == 0) begin
            checks++; failures++;
            $display("FAIL acc_unexpected: addr 0x%08h, required none",
                     cur.addr);
          end else begin
            ex = aq.pop_front();
            check("m_addr", cur.addr, ex.addr);
            check("m_we", 32'(cur.we), 32'(ex.we));
            if (ex.we) check("m_wdata", cur.wdata, ex.wdata);
            if (ex.len >= 0) check("m_req_len", 32'(len), 32'(ex.len));
          end
        end
        // Idle-time ready pulses must be ignored.
        m_ready = 1'b1;
        m_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  // Response monitor: pops the scoreboard on every done pulse.
  initial begin
    bit    prev_ready = 0;
    bit    prev_done = 0;
    resp_t r;
    forever begin
      @(negedge clk); #1;
      if (i_done || d_done) begin
        if (rq.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_unexpected: i_done=%0b d_done=%0b, required none",
                   i_done, d_done);
        end else begin
          r = rq.pop_front();
          check("done_side", {30'd0, i_done, d_done},
                r.is_i ? 32'd2 : 32'd1);
          check("rdata", r.is_i ? i_rdata : d_rdata, r.rdata);
          check("other_rdata", r.is_i ? d_rdata : i_rdata, r.other);
          check("err", 32'(err), 32'(r.err));
          if (!r.err) check("ready_before_done", 32'(prev_ready), 32'd1);
        end
        check("done_single_cycle", 32'(prev_done), 32'd0);
      end else if (err) begin
        checks++; failures++;
        $display("FAIL err_without_done: err=1, required 0");
      end
      prev_ready = m_ready;
      prev_done  = i_done || d_done;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n = 1'b0;
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_m_req", 32'(m_req), 32'd0);
    check("rst_m_we", 32'(m_we), 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_m_wdata", m_wdata, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_done", {30'd0, i_done, d_done}, 32'd0);
    check("rst_busy_err", {30'd0, busy, err}, 32'd0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    repeat (2) @(posedge clk);

    // Fetch, two wait cycles.
    lat = 2;
    push_a(32'h100, 0, '0, 3);
    push_r(1, 32'h1000_0100, 32'h0, 0);
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h100;
    @(negedge clk);
    check("fetch_pre_m_req", 32'(m_req), 32'd0);
    @(negedge clk);
    check("fetch_m_req", 32'(m_req), 32'd1);
    check("fetch_busy", 32'(busy), 32'd1);
    check("fetch_m_addr", m_addr, 32'h100);
    hold_i(1);
    repeat (2) @(posedge clk);

    // Load answered on the 4th wait cycle: normal completion.
    lat = 3;
    push_a(32'h600, 0, '0, 4);
    push_r(0, 32'h1000_0600, 32'h1000_0100, 0);
    @(posedge clk); #1;
    d_req = 1; d_we = 0; d_addr = 32'h600;
    hold_d(1);
    repeat (2) @(posedge clk);

    // Store with immediate ready leaves d_rdata untouched.
    lat = 0;
    push_a(32'h200, 1, 32'hDEAD_BEEF, 1);
    push_r(0, 32'h1000_0600, 32'h1000_0100, 0);
    @(posedge clk); #1;
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    hold_d(1);
    d_we = 0;
    repeat (2) @(posedge clk);

    // Load with no ready: timeout after 4 cycles.
    lat = 1000;
    push_a(32'h500, 0, '0, 4);
    push_r(0, 32'h0, 32'h1000_0100, 1);
    @(posedge clk); #1;
    d_req = 1; d_addr = 32'h500;
    hold_d(1);
    repeat (2) @(posedge clk);

    // Reset pulsed during a data access.
    push_a(32'h700, 0, '0, -1);
    @(posedge clk); #1;
    d_req = 1; d_addr = 32'h700;
    repeat (3) @(negedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    check("rst_mid_m_req", 32'(m_req), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done_err", {29'd0, i_done, d_done, err}, 32'd0);
    check("rst_mid_i_rdata", i_rdata, 32'd0);
    d_req = 0;
    repeat (2) @(negedge clk);

    // Contention held from reset: I, D, I, D.
    lat = 1;
    i_req = 1; i_addr = 32'h300;
    d_req = 1; d_we = 0; d_addr = 32'h400;
    push_a(32'h300, 0, '0, 2);
    push_a(32'h400, 0, '0, 2);
    push_a(32'h300, 0, '0, 2);
    push_a(32'h400, 0, '0, 2);
    push_r(1, 32'h1000_0300, 32'h0, 0);
    push_r(0, 32'h1000_0400, 32'h1000_0300, 0);
    push_r(1, 32'h1000_0300, 32'h1000_0400, 0);
    push_r(0, 32'h1000_0400, 32'h1000_0300, 0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    fork
      hold_i(2);
      hold_d(2);
    join
    repeat (5) @(negedge clk);
    check("end_busy", 32'(busy), 32'd0);
    check("resp_queue_empty", 32'(rq.size()), 32'd0);
    check("acc_queue_empty", 32'(aq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
